// File: rtl/fetch_group_sequencer_pkg.sv
// Shared types for the fetch group sequencer: run-state encoding and the
// registered fetch-group record.
package fetch_group_sequencer_pkg;

   // Storage bounds for the group record; instances use the low XLEN / ISSUE_WIDTH bits.
   localparam int MAX_XLEN  = 64;
   localparam int MAX_LANES = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } seqState_t;

   typedef struct packed {
      logic                 valid;
      logic [MAX_XLEN-1:0]  pc;
      logic [MAX_LANES-1:0] lane_mask;
   } fetchGroupStruct;

   function automatic logic [MAX_LANES-1:0] allLanes(input int lanes);
      logic [MAX_LANES-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (i < lanes) begin
            mask[i] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/fetch_group_sequencer_if.sv
// Fetch-side bus of the sequencer: group presentation with valid/ready plus
// the redirect request coming back from the front end.
interface fetch_group_sequencer_if #(
   parameter int XLEN        = 32,
   parameter int ISSUE_WIDTH = 2
);
   logic                   redirect_valid;
   logic [XLEN-1:0]        redirect_pc;
   logic                   out_valid;
   logic                   out_ready;
   logic [XLEN-1:0]        out_pc;
   logic [ISSUE_WIDTH-1:0] out_lane_mask;

   modport master (
      output out_valid,
      output out_pc,
      output out_lane_mask,
      input  out_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  out_valid,
      input  out_pc,
      input  out_lane_mask,
      output out_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/fetch_group_sequencer_lane_mask_gen.sv
// Per-lane valid mask for a group entered mid-way: lane i is live when its
// instruction address is at or beyond the redirect target.
module lane_mask_gen #(
   parameter int XLEN        = 32,
   parameter int ISSUE_WIDTH = 2,
   parameter int INST_BYTES  = 4
) (
   input  logic [XLEN-1:0]        i_target,
   input  logic [XLEN-1:0]        i_base,
   output logic [ISSUE_WIDTH-1:0] o_mask
);

   // Base is group-aligned, so base + i*INST_BYTES never wraps within a group.
   always_comb begin
      o_mask = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         o_mask[i] = (i_base + XLEN'(i * INST_BYTES)) >= i_target;
      end
   end

endmodule

// File: rtl/fetch_group_sequencer.sv
// Aligned fetch-group address generator with run/halt control, redirect
// support and a saturating accepted-group counter.
module fetch_group_sequencer
   import fetch_group_sequencer_pkg::*;
#(
   parameter int              ISSUE_WIDTH = 2,
   parameter int              XLEN        = 32,
   parameter int              INST_BYTES  = 4,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter logic [XLEN-1:0] STOP_PC     = XLEN'(240),
   parameter int              CNT_W       = 16
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_start,
   fetch_group_sequencer_if.master    bus,
   output logic                       o_halted,
   output logic [CNT_W-1:0]           o_group_count
);

   localparam int              GROUP_BYTES      = ISSUE_WIDTH * INST_BYTES;
   localparam logic [XLEN-1:0] INST_ALIGN_MASK  = ~XLEN'(INST_BYTES - 1);
   localparam logic [XLEN-1:0] GROUP_ALIGN_MASK = ~XLEN'(GROUP_BYTES - 1);

   seqState_t             r_state;
   seqState_t             w_nextState;
   fetchGroupStruct       r_group;
   fetchGroupStruct       w_nextGroup;
   logic [CNT_W-1:0]      r_count;

   logic [XLEN-1:0]        w_curPc;
   logic [XLEN:0]          w_seqSum;
   logic                   w_seqHalt;
   logic [XLEN-1:0]        w_target;
   logic [XLEN-1:0]        w_redirBase;
   logic                   w_redirHalt;
   logic [ISSUE_WIDTH-1:0] w_redirMask;
   logic                   w_accept;
   logic                   w_unusedGroupBits;

   assign w_curPc     = r_group.pc[XLEN-1:0];
   assign w_seqSum    = {1'b0, w_curPc} + (XLEN+1)'(GROUP_BYTES);
   // Carry out of the sequential add means the next group would wrap past the top.
   assign w_seqHalt   = w_seqSum[XLEN] | (w_seqSum[XLEN-1:0] > STOP_PC);
   assign w_target    = bus.redirect_pc & INST_ALIGN_MASK;
   assign w_redirBase = w_target & GROUP_ALIGN_MASK;
   assign w_redirHalt = w_redirBase > STOP_PC;
   assign w_accept    = r_group.valid & bus.out_ready;

   lane_mask_gen #(
      .XLEN        (XLEN),
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .INST_BYTES  (INST_BYTES)
   ) u_lane_mask_gen (
      .i_target (w_target),
      .i_base   (w_redirBase),
      .o_mask   (w_redirMask)
   );

   // Redirect outranks sequential advance; an unaccepted group under redirect is simply replaced.
   always_comb begin
      w_nextState = r_state;
      w_nextGroup = r_group;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_nextState           = RUN;
               w_nextGroup.valid     = 1'b1;
               w_nextGroup.pc        = MAX_XLEN'(RESET_PC);
               w_nextGroup.lane_mask = allLanes(ISSUE_WIDTH);
            end
         end
         RUN: begin
            if (bus.redirect_valid) begin
               if (w_redirHalt) begin
                  w_nextState       = HALT;
                  w_nextGroup.valid = 1'b0;
               end else begin
                  w_nextGroup.pc        = MAX_XLEN'(w_redirBase);
                  w_nextGroup.lane_mask = MAX_LANES'(w_redirMask);
               end
            end else if (w_accept) begin
               if (w_seqHalt) begin
                  w_nextState       = HALT;
                  w_nextGroup.valid = 1'b0;
               end else begin
                  w_nextGroup.pc        = MAX_XLEN'(w_seqSum[XLEN-1:0]);
                  w_nextGroup.lane_mask = allLanes(ISSUE_WIDTH);
               end
            end
         end
         HALT: begin
            w_nextGroup.valid = 1'b0;
         end
         default: begin
            w_nextState       = IDLE;
            w_nextGroup.valid = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state           <= IDLE;
         r_group.valid     <= 1'b0;
         r_group.pc        <= MAX_XLEN'(RESET_PC);
         r_group.lane_mask <= '0;
      end else begin
         r_state <= w_nextState;
         r_group <= w_nextGroup;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if ((r_state == RUN) && w_accept && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign bus.out_valid     = r_group.valid;
   assign bus.out_pc        = r_group.pc[XLEN-1:0];
   assign bus.out_lane_mask = r_group.lane_mask[ISSUE_WIDTH-1:0];
   assign o_halted          = (r_state == HALT);
   assign o_group_count     = r_count;

   // Record bits above XLEN/ISSUE_WIDTH stay constant and are trimmed by synthesis.
   assign w_unusedGroupBits = ^{r_group.pc, r_group.lane_mask};

endmodule

// File: tb/tb_fetch_group_sequencer.sv
// Directed bench: default 2-wide sequencer plus a 4-wide instance near the
// top of the address space with a narrow saturating counter.
module tb_fetch_group_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstA_n, startA, haltedA;
   logic [15:0] countA;
   logic        rstB_n, startB, haltedB;
   logic [1:0]  countB;

   int checks = 0;
   int passes = 0;

   fetch_group_sequencer_if #(.XLEN(32), .ISSUE_WIDTH(2)) busA ();
   fetch_group_sequencer_if #(.XLEN(32), .ISSUE_WIDTH(4)) busB ();

   fetch_group_sequencer dutA (
      .i_clk         (clk),
      .i_reset_n     (rstA_n),
      .i_start       (startA),
      .bus           (busA),
      .o_halted      (haltedA),
      .o_group_count (countA)
   );

   fetch_group_sequencer #(
      .ISSUE_WIDTH (4),
      .STOP_PC     (32'hFFFF_FFF0),
      .CNT_W       (2)
   ) dutB (
      .i_clk         (clk),
      .i_reset_n     (rstB_n),
      .i_start       (startB),
      .bus           (busB),
      .o_halted      (haltedB),
      .o_group_count (countB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Advance one or more cycles, leaving time 1 unit past the rising edge.
   task automatic applyStimulus(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic checkA(input string tag, input logic v, input logic [31:0] pc,
                         input logic [1:0] mask, input logic [15:0] cnt);
      checkOutput({tag, " valid"}, busA.out_valid, v);
      if (v) begin
         checkOutput({tag, " pc"}, busA.out_pc, pc);
         checkOutput({tag, " mask"}, busA.out_lane_mask, mask);
      end
      checkOutput({tag, " count"}, countA, cnt);
   endtask

   task automatic resetA();
      rstA_n = 1'b0;
      #2;
      rstA_n = 1'b1;
   endtask

   task automatic startPulseA();
      startA = 1'b1;
      applyStimulus(1);
      startA = 1'b0;
   endtask

   initial begin
      rstA_n = 1'b0; startA = 1'b0;
      rstB_n = 1'b0; startB = 1'b0;
      busA.out_ready = 1'b0; busA.redirect_valid = 1'b0; busA.redirect_pc = '0;
      busB.out_ready = 1'b0; busB.redirect_valid = 1'b0; busB.redirect_pc = '0;

      // Reset values
      #12;
      checkOutput("rst valid", busA.out_valid, 1'b0);
      checkOutput("rst pc", busA.out_pc, 32'h0);
      checkOutput("rst mask", busA.out_lane_mask, 2'b00);
      checkOutput("rst halted", haltedA, 1'b0);
      checkOutput("rst count", countA, 16'd0);
      rstA_n = 1'b1;
      applyStimulus(1);

      // Free run from 0 to 240, then halt
      busA.out_ready = 1'b1;
      startPulseA();
      for (int g = 0; g < 31; g++) begin
         checkOutput($sformatf("run valid g%0d", g), busA.out_valid, 1'b1);
         checkOutput($sformatf("run pc g%0d", g), busA.out_pc, 32'(g * 8));
         checkOutput($sformatf("run mask g%0d", g), busA.out_lane_mask, 2'b11);
         applyStimulus(1);
      end
      checkOutput("run halted", haltedA, 1'b1);
      checkOutput("run end valid", busA.out_valid, 1'b0);
      checkOutput("run end count", countA, 16'd31);
      applyStimulus(2);
      checkOutput("run halt sticky", haltedA, 1'b1);

      // Stall at 16 for three cycles
      resetA();
      applyStimulus(1);
      checkA("stall idle", 1'b0, 32'h0, 2'b00, 16'd0);
      busA.out_ready = 1'b1;
      startPulseA();
      applyStimulus(2);
      checkA("stall pre", 1'b1, 32'd16, 2'b11, 16'd2);
      busA.out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1);
         checkA($sformatf("stall hold c%0d", c), 1'b1, 32'd16, 2'b11, 16'd2);
      end
      busA.out_ready = 1'b1;
      applyStimulus(1);
      checkA("stall release", 1'b1, 32'd24, 2'b11, 16'd3);

      // Redirect to 0x2C coincident with accept of group 8
      resetA();
      busA.out_ready = 1'b1;
      startPulseA();
      applyStimulus(1);
      checkA("redir acc pre", 1'b1, 32'd8, 2'b11, 16'd1);
      busA.redirect_valid = 1'b1;
      busA.redirect_pc = 32'h2C;
      applyStimulus(1);
      busA.redirect_valid = 1'b0;
      checkA("redir acc tgt", 1'b1, 32'd40, 2'b10, 16'd2);
      applyStimulus(1);
      checkA("redir acc next", 1'b1, 32'd48, 2'b11, 16'd3);

      // Redirect to 96 while group 24 is stalled
      resetA();
      busA.out_ready = 1'b1;
      startPulseA();
      applyStimulus(3);
      checkA("redir stall pre", 1'b1, 32'd24, 2'b11, 16'd3);
      busA.out_ready = 1'b0;
      busA.redirect_valid = 1'b1;
      busA.redirect_pc = 32'd96;
      applyStimulus(1);
      busA.redirect_valid = 1'b0;
      checkA("redir stall tgt", 1'b1, 32'd96, 2'b11, 16'd3);

      // Redirect beyond the stop address halts; later start/redirect ignored
      busA.out_ready = 1'b1;
      busA.redirect_valid = 1'b1;
      busA.redirect_pc = 32'd256;
      applyStimulus(1);
      busA.redirect_valid = 1'b0;
      checkOutput("redir halt halted", haltedA, 1'b1);
      checkA("redir halt", 1'b0, 32'h0, 2'b00, 16'd4);
      startA = 1'b1;
      busA.redirect_valid = 1'b1;
      busA.redirect_pc = 32'd64;
      applyStimulus(2);
      startA = 1'b0;
      busA.redirect_valid = 1'b0;
      checkOutput("halt ignore halted", haltedA, 1'b1);
      checkA("halt ignore", 1'b0, 32'h0, 2'b00, 16'd4);

      // Asynchronous reset while stalled
      resetA();
      busA.out_ready = 1'b0;
      startPulseA();
      applyStimulus(1);
      checkA("async pre", 1'b1, 32'd0, 2'b11, 16'd0);
      #2;
      rstA_n = 1'b0;
      #1;
      checkOutput("async valid", busA.out_valid, 1'b0);
      checkOutput("async halted", haltedA, 1'b0);
      #1;
      rstA_n = 1'b1;
      applyStimulus(2);
      checkOutput("async idle valid", busA.out_valid, 1'b0);
      startPulseA();
      checkA("async restart", 1'b1, 32'd0, 2'b11, 16'd0);

      // Wide instance: saturation, mid-group redirect near the top, overflow halt
      rstB_n = 1'b1;
      busB.out_ready = 1'b1;
      startB = 1'b1;
      applyStimulus(1);
      startB = 1'b0;
      checkOutput("wide pc0", busB.out_pc, 32'd0);
      checkOutput("wide mask0", busB.out_lane_mask, 4'b1111);
      applyStimulus(1);
      checkOutput("wide pc1", busB.out_pc, 32'd16);
      checkOutput("wide count1", countB, 2'd1);
      applyStimulus(2);
      checkOutput("wide count3", countB, 2'd3);
      applyStimulus(1);
      checkOutput("wide pc4", busB.out_pc, 32'd64);
      checkOutput("wide count sat", countB, 2'd3);
      busB.out_ready = 1'b0;
      busB.redirect_valid = 1'b1;
      busB.redirect_pc = 32'hFFFF_FFF4;
      applyStimulus(1);
      busB.redirect_valid = 1'b0;
      checkOutput("wide top valid", busB.out_valid, 1'b1);
      checkOutput("wide top pc", busB.out_pc, 32'hFFFF_FFF0);
      checkOutput("wide top mask", busB.out_lane_mask, 4'b1110);
      busB.out_ready = 1'b1;
      applyStimulus(1);
      checkOutput("wide ovf halted", haltedB, 1'b1);
      checkOutput("wide ovf valid", busB.out_valid, 1'b0);
      checkOutput("wide ovf count", countB, 2'd3);
      applyStimulus(1);
      checkOutput("wide ovf no wrap", busB.out_valid, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
